// File: rtl/bin_gray_pkg.sv
// Shared Gray-code helpers and skid-buffer state type for the Gray encode/decode paths.
package bin_gray_pkg;

  localparam int unsigned MaxWidth = 32;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

  // Callers zero-extend to MaxWidth and truncate the result back to their own width.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxWidth; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bin_to_gray_stream_if.sv
// Input (binary) and output (Gray) valid/ready streams of bin_to_gray_stream.
interface bin_to_gray_stream_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gray;

  // Environment side: produces binary words, consumes Gray words.
  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_gray
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_gray
  );
endinterface

// File: rtl/bin_gray_skid.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready and out_valid.
module bin_gray_skid
  import bin_gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;
  logic             valid_q;
  logic             push;
  logic             pop;

  assign push      = in_valid & ready_q;
  assign pop       = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

  // ready/valid are written alongside the state so they always reflect the next occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          ready_q <= 1'b1;
          valid_q <= push;
          if (push) begin
            head_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_q  <= in_data;
            state_q <= FULL;
            ready_q <= 1'b0;
          end else if (pop && !push) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end else if (push && pop) begin
            head_q <= in_data;
          end
        end
        FULL: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bin_to_gray_stream.sv
// Streaming binary-to-Gray encoder over a 2-entry skid buffer.
// Define GRAY_ADJ_CHECK_EN to add the adj_err output flagging non-adjacent consecutive pops.
module bin_to_gray_stream
  import bin_gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bin_to_gray_stream_if.slave bus
`ifdef GRAY_ADJ_CHECK_EN
  ,
  output logic                adj_err
`endif
);

  logic [WIDTH-1:0] gray_in;

  // Encode at push so the buffer stores Gray words.
  assign gray_in = WIDTH'(bin2gray(MaxWidth'(bus.in_bin)));

  bin_gray_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (gray_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (bus.out_gray)
  );

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] last_q;
  logic             seen_q;
  logic             adj_err_q;
  logic             pop;

  assign pop     = bus.out_valid & bus.out_ready;
  assign adj_err = adj_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q    <= '0;
      seen_q    <= 1'b0;
      adj_err_q <= 1'b0;
    end else begin
      adj_err_q <= 1'b0;
      if (pop) begin
        last_q <= bus.out_gray;
        seen_q <= 1'b1;
        if (seen_q) begin
          adj_err_q <= popcount(MaxWidth'(bus.out_gray ^ last_q)) != 1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_gray_stream.sv
// Directed self-checking bench for bin_to_gray_stream (WIDTH = 4).
module tb_bin_to_gray_stream;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  bin_to_gray_stream_if #(.WIDTH(4)) bus ();

`ifdef GRAY_ADJ_CHECK_EN
  logic adj_err;
`endif

  bin_to_gray_stream #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef GRAY_ADJ_CHECK_EN
    ,
    .adj_err(adj_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef GRAY_ADJ_CHECK_EN
  task automatic run_pair(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic exp);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bin    = a;
    step();
    bus.in_bin = b;
    step();
    bus.in_valid = 1'b0;
    check({tag, "_first"}, 32'(adj_err), 32'd0);
    step();
    check(tag, 32'(adj_err), 32'(exp));
    step();
    check({tag, "_pulse"}, 32'(adj_err), 32'd0);
  endtask
`endif

  initial begin
    int s;
    int r;
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bin    = '0;
    bus.out_ready = 1'b0;

    // Reset
    repeat (3) step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_gray", 32'(bus.out_gray), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single word
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bin    = 4'b0101;
    step();
    bus.in_valid = 1'b0;
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_gray", 32'(bus.out_gray), 32'h7);
    step();
    check("single_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_bin    = 4'd3;
    step();
    check("bp_ready1", 32'(bus.in_ready), 32'd1);
    check("bp_gray1", 32'(bus.out_gray), 32'h2);
    bus.in_bin = 4'd4;
    step();
    bus.in_valid = 1'b0;
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    check("bp_hold_gray", 32'(bus.out_gray), 32'h2);
    step();
    check("bp_hold_again", 32'(bus.out_gray), 32'h2);
    bus.out_ready = 1'b1;
    step();
    check("bp_pop1_ready", 32'(bus.in_ready), 32'd1);
    check("bp_pop1_valid", 32'(bus.out_valid), 32'd1);
    check("bp_gray2", 32'(bus.out_gray), 32'h6);
    step();
    check("bp_drain", 32'(bus.out_valid), 32'd0);

    // Back-to-back stream with out_ready held high
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bin   = 4'(i);
      step();
      check($sformatf("stream_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("stream_gray%0d", i), 32'(bus.out_gray), 32'(gray_tbl[i]));
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_drain", 32'(bus.out_valid), 32'd0);

    // Random out_ready: same order, no loss or duplication
    s = 0;
    r = 0;
    for (int cyc = 0; cyc < 400 && r < 16; cyc++) begin
      bus.in_valid  = (s < 16);
      bus.in_bin    = 4'(s);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (r < 16) check($sformatf("rand_gray%0d", r), 32'(bus.out_gray), 32'(gray_tbl[r]));
        r++;
      end
      if (bus.in_valid && bus.in_ready) s++;
      step();
    end
    bus.in_valid = 1'b0;
    check("rand_count", 32'(r), 32'd16);
    check("rand_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset with a full buffer
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_bin    = 4'd1;
    step();
    bus.in_bin = 4'd2;
    step();
    bus.in_valid = 1'b0;
    check("mid_full_ready", 32'(bus.in_ready), 32'd0);
    check("mid_full_gray", 32'(bus.out_gray), 32'h1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("mid_post_ready", 32'(bus.in_ready), 32'd1);
    check("mid_post_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("mid_no_ghost", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_bin   = 4'd10;
    step();
    bus.in_valid = 1'b0;
    check("mid_new_gray", 32'(bus.out_gray), 32'hF);
    step();
    check("mid_new_drain", 32'(bus.out_valid), 32'd0);

`ifdef GRAY_ADJ_CHECK_EN
    run_pair("adj_7_8", 4'd7, 4'd8, 1'b0);
    run_pair("adj_7_9", 4'd7, 4'd9, 1'b1);
    run_pair("adj_15_0", 4'd15, 4'd0, 1'b0);
    run_pair("adj_5_5", 4'd5, 4'd5, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
